// File: rtl/rob_pkg.sv
// rob_pkg: shared sizing and entry record for the reorder buffer.
// Entry field widths here set the storage inside each rob_entry; keep them
// equal to the DEST_WIDTH / DATA_WIDTH parameters of rob_ctrl.
package rob_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
    localparam int ROB_DEST_W = 5;
    localparam int ROB_DATA_W = 32;

    typedef struct packed {
        logic                  complete;
        logic [ROB_DEST_W-1:0] dest;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry.sv
// rob_entry: one reorder slot. Holds the complete flag (reset/cleared) and the
// destination/result payload (never reset). Alloc write beats writeback.
module rob_entry
    import rob_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_alloc_we,
    input  logic [ROB_DEST_W-1:0] i_alloc_dest,
    input  logic                  i_wb_we,
    input  logic [ROB_DATA_W-1:0] i_wb_data,
    input  logic                  i_commit_clr,
    output rob_entry_t            o_entry
);

    logic                  r_complete;
    logic [ROB_DEST_W-1:0] r_dest;
    logic [ROB_DATA_W-1:0] r_data;

    // Complete flag: cleared by reset/flush/alloc/retire, set by writeback.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_complete <= 1'b0;
        end else if (i_clr) begin
            r_complete <= 1'b0;
        end else if (i_alloc_we) begin
            r_complete <= 1'b0;
        end else if (i_commit_clr) begin
            r_complete <= 1'b0;
        end else if (i_wb_we) begin
            r_complete <= 1'b1;
        end
    end

    // Payload storage: no reset, written on alloc (dest) and writeback (data).
    always_ff @(posedge i_clk) begin
        if (i_alloc_we) begin
            r_dest <= i_alloc_dest;
        end
        if (i_wb_we && !i_alloc_we) begin
            r_data <= i_wb_data;
        end
    end

    assign o_entry.complete = r_complete;
    assign o_entry.dest     = r_dest;
    assign o_entry.data     = r_data;

endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller. Circular buffer of rob_entry slots with
// in-order allocate, out-of-order writeback and in-order commit.
// Optional feature: define ROB_FLUSH_EN to add the flush_i port, which
// returns the buffer to its reset state on the next clock edge.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int DATA_WIDTH = ROB_DATA_W,
    parameter int DEST_WIDTH = ROB_DEST_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid_i,
    input  logic [DEST_WIDTH-1:0]      alloc_dest_i,
    output logic                       alloc_ready_o,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag_o,
    input  logic                       wb_valid_i,
    input  logic [$clog2(DEPTH)-1:0]   wb_tag_i,
    input  logic [DATA_WIDTH-1:0]      wb_data_i,
    output logic                       commit_valid_o,
    input  logic                       commit_ready_i,
    output logic [DEST_WIDTH-1:0]      commit_dest_o,
    output logic [DATA_WIDTH-1:0]      commit_data_o,
`ifdef ROB_FLUSH_EN
    input  logic                       flush_i,
`endif
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] LP_FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    logic             w_alloc_fire;
    logic             w_commit_fire;
    logic [TAG_W-1:0] w_wb_off;
    logic             w_wb_occ;
    rob_entry_t       w_head_entry;
    rob_entry_t       w_entries [DEPTH];
    logic [DEPTH-1:0] w_alloc_we;
    logic [DEPTH-1:0] w_wb_we;
    logic [DEPTH-1:0] w_commit_clr;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Occupancy flags come straight from the registered count, so a commit in
    // the same cycle never reopens a full buffer for allocation.
    assign w_full  = (r_count == LP_FULL_CNT);
    assign w_empty = (r_count == '0);

    assign w_head_entry  = w_entries[r_head];
    assign w_alloc_fire  = alloc_valid_i && !w_full;
    assign w_commit_fire = !w_empty && w_head_entry.complete && commit_ready_i;

    // A tag is live when its distance from head (mod DEPTH) is below count.
    assign w_wb_off = wb_tag_i - r_head;
    assign w_wb_occ = ({1'b0, w_wb_off} < r_count);

    assign alloc_ready_o  = !w_full;
    assign alloc_tag_o    = r_tail;
    assign commit_valid_o = !w_empty && w_head_entry.complete;
    assign commit_dest_o  = w_empty ? '0 : w_head_entry.dest;
    assign commit_data_o  = w_empty ? '0 : w_head_entry.data;
    assign count_o        = r_count;
    assign full_o         = w_full;
    assign empty_o        = w_empty;

    // Per-slot write strobes and slot instances.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_alloc_we[g]   = w_alloc_fire && (r_tail == TAG_W'(g));
        assign w_wb_we[g]      = wb_valid_i && w_wb_occ && (wb_tag_i == TAG_W'(g));
        assign w_commit_clr[g] = w_commit_fire && (r_head == TAG_W'(g));

        rob_entry u_entry (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_clr        (w_flush),
            .i_alloc_we   (w_alloc_we[g]),
            .i_alloc_dest (alloc_dest_i),
            .i_wb_we      (w_wb_we[g]),
            .i_wb_data    (wb_data_i),
            .i_commit_clr (w_commit_clr[g]),
            .o_entry      (w_entries[g])
        );
    end

    // Head/tail pointers and occupancy count; flush overrides any fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + TAG_W'(1);
            end
            if (w_commit_fire) begin
                r_head <= r_head + TAG_W'(1);
            end
            case ({w_alloc_fire, w_commit_fire})
                2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of reorder entries, power of two, minimum 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: result width.
REQ-003 SHALL have parameter DEST_WIDTH, default 5: architectural destination register index width.
REQ-004 SHALL have ports in this order:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alloc_valid_i  in  1  dispatch requests an entry.
- alloc_dest_i  in  DEST_WIDTH  destination of the dispatched instruction.
- alloc_ready_o  out  1  entry available.
- alloc_tag_o  out  TAG_W  tag granted; TAG_W = log2(DEPTH).
- wb_valid_i  in  1  execution result valid.
- wb_tag_i  in  TAG_W  tag being completed.
- wb_data_i  in  DATA_WIDTH  result.
- commit_valid_o  out  1  head entry is complete.
- commit_ready_i  in  1  retire stage accepts the head entry.
- commit_dest_o  out  DEST_WIDTH  head destination.
- commit_data_o  out  DATA_WIDTH  head result.
- flush_i  in  1  discard all entries; present only under ROB_FLUSH_EN.
- count_o  out  TAG_W+1  occupied entries.
- full_o, empty_o  out  1 each  occupancy flags.

Function
REQ-005 SHALL form a circular buffer using head and tail pointers of TAG_W bits plus a count of TAG_W+1 bits; both pointers wrap DEPTH-1 -> 0.
REQ-006 SHALL drive alloc_ready_o = !full_o and alloc_tag_o = tail, both from registered state only.
REQ-007 SHALL treat an allocation fire as alloc_valid_i && alloc_ready_o. On a fire the entry at tail gets complete=0 and dest=alloc_dest_i, and tail increments, all on the same edge.
REQ-008 SHALL, on wb_valid_i, set complete=1 and store wb_data_i at wb_tag_i if that entry is occupied. A writeback to an unoccupied tag SHALL be ignored.
REQ-009 SHALL assert commit_valid_o = !empty_o && complete[head], with dest and data taken from the head entry. There is no writeback-to-commit bypass: a writeback is visible at commit on the next cycle (latency 1).
REQ-010 SHALL treat a commit fire as commit_valid_o && commit_ready_i. On a fire head increments and the entry's complete bit clears.
REQ-011 SHALL leave count unchanged on a simultaneous alloc fire and commit fire, increment it on alloc fire only, and decrement it on commit fire only.
REQ-012 SHALL keep alloc_ready_o low when full, even if a commit fires in the same cycle (no full-bypass).
REQ-013 SHALL drive full_o = (count == DEPTH) and empty_o = (count == 0). commit_dest_o and commit_data_o SHALL be 0 when empty.
REQ-014 SHALL, when a writeback and a commit target the same entry in one cycle, never fire that commit, because complete was 0 at the edge.

Reset
REQ-015 SHALL, on rst assertion at any time including mid-operation, immediately set head=0, tail=0, count=0 and clear all complete bits. Resulting outputs: alloc_ready_o=1, alloc_tag_o=0, commit_valid_o=0, commit_dest_o=0, commit_data_o=0, count_o=0, full_o=0, empty_o=1.
REQ-016 SHALL leave dest and data storage unreset.

Configuration
REQ-017 SHALL compile the flush_i port and its logic in only when macro ROB_FLUSH_EN is defined.
REQ-018 With ROB_FLUSH_EN defined, flush_i high SHALL, at the next edge, produce the reset state of REQ-015. Flush SHALL override any alloc, writeback or commit in the same cycle, and outputs are not gated during the flush cycle.
REQ-019 Without ROB_FLUSH_EN, the block SHALL have no flush_i port, and only rst clears state.

Structure
REQ-020 SHALL place ROB_DEPTH, ROB_TAG_W and typedef rob_entry_t {complete, dest, data} in shared package rob_pkg.
REQ-021 SHALL instantiate DEPTH copies of sub-module rob_entry. Each copy holds one rob_entry_t and has an alloc-write port and a writeback-write port; alloc has priority if both hit the same entry.

Verification
REQ-022 Reset then 16 allocs, no writebacks -> tags 0..15 granted, full_o=1 after the 16th, alloc_ready_o=0, commit_valid_o=0.
REQ-023 Alloc tags 0,1,2; writeback tag 1 then tag 0 with data 0xA, commit_ready_i=1 -> tag 0 commits with 0xA the cycle after its writeback, then tag 1 commits; tag 2 held.
REQ-024 Full buffer, head complete, alloc_valid_i=1 and commit fire in the same cycle -> commit accepted, alloc rejected, count goes 16 -> 15, alloc accepted next cycle.
REQ-025 Wrap-around: 40 alloc/writeback/commit cycles at steady count 3 -> tags wrap 15 -> 0, commits stay in order, data matches.
REQ-026 Writeback to unallocated tag 7 with count=2 -> no state change. Writeback and commit_ready on the head in the same cycle -> commit occurs one cycle later.
REQ-027 With ROB_FLUSH_EN, count=5 and flush_i pulsed together with alloc_valid_i -> count_o=0, empty_o=1, alloc_tag_o=0 next cycle. rst asserted mid-stream -> outputs match REQ-015 before the next clock edge.
